// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter and the 7-segment display path.
package bcd_pkg;

  localparam logic [3:0] BCD_MINUS = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

  // Smallest digit count d with 10^d > 2^(width-1), i.e. enough for any signed magnitude.
  function automatic int digits_needed(input int width);
    longint limit;
    longint pow10;
    int     d;
    limit = longint'(1) << (width - 1);
    pow10 = 1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= limit) begin
        pow10 = pow10 * 10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One shift-add-3 correction cell: a BCD digit of 5 or more is pre-biased by 3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle signed binary to display-coded BCD converter (double dabble), one bit per clock,
// with valid/ready handshakes on both sides and optional leading-zero blanking.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          bin_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [4*(DIGITS+1)-1:0]   digits_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 4..16");
  end
  if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  bcd_state_t                state_reg;
  logic                      neg_reg;
  logic [WIDTH-1:0]          mag_reg;
  logic [BCD_W-1:0]          bcd_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [4*(DIGITS+1)-1:0]   digits_reg;

  logic [WIDTH-1:0]          mag_in;
  logic [BCD_W-1:0]          bcd_adj;
  logic [BCD_W-1:0]          bcd_shift;
  logic [WIDTH-1:0]          mag_shift;
  logic [BCD_W-1:0]          disp_digits;
  logic [DIGITS:1]           lead_zero;
  logic [4*(DIGITS+1)-1:0]   digits_next;

  // Two's-complement negate in WIDTH bits; the most negative value lands on 2^(WIDTH-1) unsigned.
  assign mag_in = bin_i[WIDTH-1] ? (~bin_i + WIDTH'(1)) : bin_i;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (bcd_reg[4*gi +: 4]),
      .adjusted (bcd_adj[4*gi +: 4])
    );
  end

  assign {bcd_shift, mag_shift} = {bcd_adj, mag_reg} << 1;

  // lead_zero[k] is set when digits k and above are all zero; the units digit is never blanked.
  assign lead_zero[DIGITS] = 1'b1;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
    assign lead_zero[gi] = lead_zero[gi+1] & (bcd_reg[4*gi +: 4] == 4'd0);
  end

  assign disp_digits[3:0] = bcd_reg[3:0];
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_disp
    assign disp_digits[4*gi +: 4] = (BLANK_LZ && lead_zero[gi]) ? BCD_BLANK : bcd_reg[4*gi +: 4];
  end

  assign digits_next = {(neg_reg ? BCD_MINUS : BCD_BLANK), disp_digits};

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      neg_reg    <= 1'b0;
      mag_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      digits_reg <= {(DIGITS+1){BCD_BLANK}};
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            neg_reg   <= bin_i[WIDTH-1];
            mag_reg   <= mag_in;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt_reg == CNT_W'(WIDTH)) begin
            digits_reg <= digits_next;
            state_reg  <= DONE;
          end else begin
            bcd_reg <= bcd_shift;
            mag_reg <= mag_shift;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign valid_o  = (state_reg == DONE);
  assign digits_o = digits_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: two instances (blanking on/off) share stimulus and are checked per result.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  bin_i;
  logic        valid_i;
  logic        ready_i;
  logic        ready_o, valid_o;
  logic        ready_o_nb, valid_o_nb;
  logic [15:0] digits_o, digits_o_nb;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .bin_i    (bin_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .digits_o (digits_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk      (clk),
    .rst_i    (rst_i),
    .bin_i    (bin_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o_nb),
    .digits_o (digits_o_nb),
    .valid_o  (valid_o_nb),
    .ready_i  (ready_i)
  );

  typedef struct packed {
    logic [15:0] lz;
    logic [15:0] nolz;
    logic [7:0]  val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   ready_rand  = 1'b0;
  logic ready_fixed = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_digits(input logic [7:0] v, input bit blank);
    int          m;
    int          d[3];
    bit          lead;
    logic [15:0] r;
    m    = v[7] ? 256 - int'(v) : int'(v);
    d[0] = m % 10;
    d[1] = (m / 10) % 10;
    d[2] = m / 100;
    r[15:12] = v[7] ? 4'hA : 4'hF;
    lead = 1'b1;
    for (int k = 2; k >= 1; k--) begin
      lead = lead && (d[k] == 0);
      r[4*k +: 4] = (blank && lead) ? 4'hF : 4'(d[k]);
    end
    r[3:0] = 4'(d[0]);
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Single driver for ready_i; runs 1 ns after the stimulus writers so mode changes take effect this cycle.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Monitor: push on accept, pop and compare on consume, plus handshake and latency checks.
  initial begin
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    logic [15:0] pd = 16'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        exp_q.delete();
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          check_val("valid_held", 32'(valid_o), 32'd1);
          check_val("digits_held", 32'(digits_o), 32'(pd));
        end
        if (valid_o) check_val("ready_in_done", 32'(ready_o), 32'd0);
        if (valid_o && !pv) check_val("latency", 32'(cyc - acc_cyc), 32'd9);
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            check_val("spurious_valid", 32'(valid_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val($sformatf("result_%0d", $signed(e.val)), 32'(digits_o), 32'(e.lz));
            check_val($sformatf("result_nolz_%0d", $signed(e.val)), 32'(digits_o_nb), 32'(e.nolz));
            check_val("valid_nolz", 32'(valid_o_nb), 32'd1);
          end
        end
        if (valid_i && ready_o) begin
          exp_q.push_back('{lz: ref_digits(bin_i, 1'b1), nolz: ref_digits(bin_i, 1'b0), val: bin_i});
          acc_cyc = cyc + 1;
        end
        pv = valid_o;
        pr = ready_i;
        pd = digits_o;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    check_val({tag, "_digits"}, 32'(digits_o), 32'hFFFF);
    check_val({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_val({tag, "_ready"}, 32'(ready_o), 32'd1);
    check_val({tag, "_digits_nolz"}, 32'(digits_o_nb), 32'hFFFF);
  endtask

  task automatic send(input logic [7:0] v);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!ready_o) check_val("send_timeout", 32'(ready_o), 32'd1);
    bin_i   = v;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !ready_o) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t;
    rst_i   = 1'b1;
    bin_i   = 8'h00;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_reset("post_reset");

    send(8'd127);  wait_idle();
    send(8'h80);   wait_idle();
    send(8'hFF);   wait_idle();
    send(8'h00);   wait_idle();

    // Backpressure: result must sit unchanged while ready_i is low.
    ready_fixed = 1'b0;
    send(8'd42);
    t = 0;
    while (!valid_o && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("bp_valid_up", 32'(valid_o), 32'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      check_val("bp_valid", 32'(valid_o), 32'd1);
      check_val("bp_digits", 32'(digits_o), 32'hFF42);
      check_val("bp_ready", 32'(ready_o), 32'd0);
    end
    ready_fixed = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("bp_release_valid", 32'(valid_o), 32'd0);
    check_val("bp_release_ready", 32'(ready_o), 32'd1);
    check_val("bp_digits_kept", 32'(digits_o), 32'hFF42);
    wait_idle();

    // Busy-ignore: valid_i stays high with a new value during the conversion.
    bin_i   = 8'd10;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    bin_i = 8'd99;
    t = 0;
    while (!ready_o && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_idle();

    // Reset in the middle of a conversion.
    send(8'd77);
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_reset("after_mid_reset");
    send(8'hC7);
    wait_idle();

    // Full sweep with random downstream stalls.
    ready_rand = 1'b1;
    for (int v = -128; v < 128; v++) begin
      send(8'(v));
    end
    wait_idle();
    ready_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
